stream_demux: RTL

- Packet-level demultiplexer: the receive-side counterpart of the QoS stream arbiter.
- Takes the single merged stream (data, qos, id, last) and steers each packet to output stream m_*[id].
- Route is locked for the whole packet. Each output has a one-entry register slice, so every output is registered.
- Sits downstream of the arbiter / link and feeds STREAM_COUNT per-stream consumers.

---
 rtl/stream_demux.sv | 94 +++++++++
 1 files changed

// File: rtl/stream_demux.sv
// stream_demux: steers each packet of a merged stream to m_*[id] through per-output register slices.
// Optional STREAM_DEMUX_DROP_STAT_EN adds err_drop_o / drop_cnt_o for out-of-range packets.
module stream_demux #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 2,
    localparam int ID_W = $clog2(STREAM_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_QOS__WIDTH-1:0] s_qos_i,
    input  logic [ID_W-1:0]         s_id_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [STREAM_COUNT],
    output logic [T_QOS__WIDTH-1:0] m_qos_o  [STREAM_COUNT],
    output logic [STREAM_COUNT-1:0] m_last_o,
    output logic [STREAM_COUNT-1:0] m_valid_o,
`ifdef STREAM_DEMUX_DROP_STAT_EN
    output logic                    err_drop_o,
    output logic [15:0]             drop_cnt_o,
`endif
    input  logic [STREAM_COUNT-1:0] m_ready_i
);
    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;
    state_t r_state, w_next;
    logic [ID_W-1:0] r_route, w_sel;
    logic [STREAM_COUNT-1:0] r_valid;
    logic w_id_ok, w_drop, w_acc, w_first_drop;

    assign w_id_ok      = 32'(s_id_i) < STREAM_COUNT;
    assign w_sel        = (r_state == IDLE) ? s_id_i : r_route;
    assign w_drop       = (r_state == DROP) || (r_state == IDLE && !w_id_ok);
    // out-of-range sel is masked by w_drop, so the stray index read is harmless
    assign s_ready_o    = w_drop || !r_valid[w_sel] || m_ready_i[w_sel];
    assign w_acc        = s_valid_i && s_ready_o;
    assign w_first_drop = w_acc && r_state == IDLE && !w_id_ok;
    assign m_valid_o    = r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_route <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc && r_state == IDLE && w_id_ok && !s_last_i) r_route <= s_id_i;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_acc) begin
            if (r_state == IDLE) w_next = s_last_i ? IDLE : (w_id_ok ? ROUTE : DROP);
            else if (s_last_i)   w_next = IDLE;
        end
    end

    for (genvar k = 0; k < STREAM_COUNT; k++) begin : g_slice
        logic w_load;
        assign w_load = w_acc && !w_drop && 32'(w_sel) == k;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid[k]  <= 1'b0;
                m_data_o[k] <= '0;
                m_qos_o[k]  <= '0;
                m_last_o[k] <= 1'b0;
            end else begin
                r_valid[k] <= w_load || (r_valid[k] && !m_ready_i[k]);
                if (w_load) begin
                    m_data_o[k] <= s_data_i;
                    m_qos_o[k]  <= s_qos_i;
                    m_last_o[k] <= s_last_i;
                end
            end
        end
    end

`ifdef STREAM_DEMUX_DROP_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_drop_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            err_drop_o <= w_first_drop;
            if (w_first_drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_first_drop;
`endif
endmodule
